program_counter: RTL and testbench
==================================

PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 Parameter DataWidth, default 16, width of address path and stack entries.
REQ-002 Parameter IncStep, default 1, increment added on Inc and to form return address.
REQ-003 Parameter StackDepth, default 4, return-stack entries; minimum 2.
REQ-004 Parameter ResetVector, default 0, DOut value after reset.
REQ-005 Clk  input  1  single clock; all state changes on rising edge.
REQ-006 Reset  input  1  asynchronous, active-high reset.
REQ-007 LD  input  1  active-high load: DOut <= DIn.
REQ-008 Inc  input  1  active-high increment: DOut <= DOut + IncStep.
REQ-009 Call  input  1  active-high call: push return address, DOut <= DIn.
REQ-010 Ret  input  1  active-high return: DOut <= top of stack, pop.
REQ-011 DIn  input  DataWidth  load/call target.
REQ-012 DOut  output  DataWidth  registered program counter value.
REQ-013 Full  output  1  stack holds StackDepth entries.
REQ-014 Empty  output  1  stack holds zero entries.
REQ-015 Err  output  1  registered one-cycle pulse on stack overflow/underflow attempt.

Function
REQ-016 Priority per cycle SHALL be Ret > Call > LD > Inc > hold; exactly one operation executes.
REQ-017 Latency SHALL be one cycle: DOut reflects the operation after the rising edge that samples the request.
REQ-018 Inc SHALL wrap modulo 2^DataWidth (0xFFFF + 1 -> 0x0000 at DataWidth=16).
REQ-019 Call SHALL push (DOut + IncStep) mod 2^DataWidth and load DIn in the same edge.
REQ-020 Ret SHALL load the top entry into DOut and decrement the stack count in the same edge.
REQ-021 Call while Full SHALL not push, not change DOut, and pulse Err for one cycle.
REQ-022 Ret while Empty SHALL not change DOut or count and pulse Err for one cycle.
REQ-023 Call and Ret in the same cycle SHALL execute Ret only (per REQ-016); Call is dropped without Err.
REQ-024 Full and Empty SHALL decode combinationally from the registered stack count.
REQ-025 Err SHALL be 0 in every cycle not covered by REQ-021/REQ-022.

Reset
REQ-026 Reset assertion SHALL immediately force DOut=ResetVector, stack count=0, Err=0, independent of Clk.
REQ-027 Reset SHALL override any in-progress operation; stack entry contents need not be cleared.
REQ-028 First operation SHALL be honoured on the first rising edge after Reset deasserts.

Configuration
REQ-029 Macro PC_STACK_EN present: return stack, Full, Empty and Err SHALL behave as REQ-019..REQ-025.
REQ-030 PC_STACK_EN absent: no stack storage; Call SHALL act as LD, Ret SHALL act as hold, Full=0, Empty=1, Err=0 constantly.

Structure
REQ-031 Shared package pc_pkg SHALL hold the operation enum (OP_HOLD, OP_INC, OP_LD, OP_CALL, OP_RET) and default parameter constants.
REQ-032 Return stack SHALL be a sub-module pc_stack (push, pop, top, count, full, empty), instantiated only under PC_STACK_EN.
REQ-033 Top level SHALL contain the priority decoder producing one pc_pkg operation per cycle and the DOut register.

Verification (DataWidth=16, IncStep=1, StackDepth=4, ResetVector=0)
REQ-034 Reset pulse mid-cycle with DOut=0x1234 -> DOut=0x0000, Empty=1, Err=0 before next edge.
REQ-035 LD with DIn=0x00A0, then 3 cycles Inc -> DOut=0x00A0, 0x00A1, 0x00A2, 0x00A3; LD 0xFFFF then Inc -> 0x0000.
REQ-036 DOut=0x0010, Call DIn=0x0200, then Ret -> DOut=0x0200, then 0x0011, Empty=1 after Ret.
REQ-037 Four Calls from DOut=0x0000 (targets 0x0100..0x0400) -> Full=1; fifth Call 0x0500 -> DOut stays 0x0400, Err=1 one cycle.
REQ-038 Ret with Empty=1 and DOut=0x0050 -> DOut stays 0x0050, Err=1 one cycle; Call+Ret+LD together with one entry 0x0011 -> DOut=0x0011.
REQ-039 Build without PC_STACK_EN: Call DIn=0x0300 -> DOut=0x0300; Ret -> DOut unchanged, Err=0, Full=0, Empty=1.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared operation encoding and default parameters for program_counter
package pc_pkg;
  typedef enum logic [2:0] {OP_HOLD, OP_INC, OP_LD, OP_CALL, OP_RET} pc_op_e;
  localparam int PC_DATA_WIDTH   = 16;
  localparam int PC_INC_STEP     = 1;
  localparam int PC_STACK_DEPTH  = 4;
  localparam int PC_RESET_VECTOR = 0;
endpackage

// File: rtl/pc_stack.sv
// pc_stack: LIFO return stack; ports clk/rst, push/pop/push_data in, top/count/full/empty out
module pc_stack #(
  parameter int DataWidth  = 16,
  parameter int StackDepth = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  logic                            pop,
  input  logic [DataWidth-1:0]            push_data,
  output logic [DataWidth-1:0]            top,
  output logic [$clog2(StackDepth+1)-1:0] count,
  output logic                            full,
  output logic                            empty
);
  localparam int CW = $clog2(StackDepth + 1);
  localparam int IW = $clog2(StackDepth);
  logic [DataWidth-1:0] mem_q [StackDepth];
  logic [CW-1:0]        count_d, count_q;
  logic [IW-1:0]        top_idx;
  always_comb begin
    full    = count_q == CW'(StackDepth);
    empty   = count_q == '0;
    top_idx = IW'(count_q - 1'b1);
    top     = empty ? '0 : mem_q[top_idx];
    count_d = push && !full ? count_q + 1'b1 : pop && !empty ? count_q - 1'b1 : count_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) count_q <= '0;
    else count_q <= count_d;
  always_ff @(posedge clk)
    if (push && !full) mem_q[IW'(count_q)] <= push_data;
  assign count = count_q;
endmodule

// File: rtl/program_counter.sv
// program_counter: PC with Ret>Call>LD>Inc priority; ports Clk/Reset/LD/Inc/Call/Ret/DIn in, DOut/Full/Empty/Err out; return stack only with PC_STACK_EN
module program_counter
  import pc_pkg::*;
#(
  parameter int DataWidth   = PC_DATA_WIDTH,
  parameter int IncStep     = PC_INC_STEP,
  parameter int StackDepth  = PC_STACK_DEPTH,
  parameter int ResetVector = PC_RESET_VECTOR
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 LD,
  input  logic                 Inc,
  input  logic                 Call,
  input  logic                 Ret,
  input  logic [DataWidth-1:0] DIn,
  output logic [DataWidth-1:0] DOut,
  output logic                 Full,
  output logic                 Empty,
  output logic                 Err
);
  pc_op_e               op;
  logic [DataWidth-1:0] dout_d, dout_q, next_addr;
  if (StackDepth < 2) begin : g_bad_depth
    $error("StackDepth must be at least 2");
  end
  always_comb op = Ret ? OP_RET : Call ? OP_CALL : LD ? OP_LD : Inc ? OP_INC : OP_HOLD;
  assign next_addr = dout_q + DataWidth'(IncStep);
`ifdef PC_STACK_EN
  logic                            push, pop, err_d, err_q, stk_full, stk_empty;
  logic [DataWidth-1:0]            stk_top;
  logic [$clog2(StackDepth+1)-1:0] stk_count;
  always_comb begin
    push   = op == OP_CALL && !stk_full;
    pop    = op == OP_RET && !stk_empty;
    err_d  = (op == OP_CALL && stk_full) || (op == OP_RET && stk_empty);
    dout_d = op == OP_RET  ? (stk_empty ? dout_q : stk_top) :
             op == OP_CALL ? (stk_full ? dout_q : DIn) :
             op == OP_LD   ? DIn :
             op == OP_INC  ? next_addr : dout_q;
  end
  pc_stack #(.DataWidth(DataWidth), .StackDepth(StackDepth)) u_stack (
    .clk(Clk), .rst(Reset), .push(push), .pop(pop), .push_data(next_addr),
    .top(stk_top), .count(stk_count), .full(stk_full), .empty(stk_empty)
  );
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) err_q <= 1'b0;
    else err_q <= err_d;
  assign Full  = stk_full;
  assign Empty = stk_empty;
  assign Err   = err_q;
`else
  always_comb
    dout_d = op == OP_CALL || op == OP_LD ? DIn : op == OP_INC ? next_addr : dout_q;
  assign Full  = 1'b0;
  assign Empty = 1'b1;
  assign Err   = 1'b0;
`endif
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) dout_q <= DataWidth'(ResetVector);
    else dout_q <= dout_d;
  assign DOut = dout_q;
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: randomized and directed checks of program_counter against a queue-based model
module tb_program_counter;
`ifdef PC_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif
  logic        clk = 1'b0, rst = 1'b1, ld = 1'b0, inc = 1'b0, call = 1'b0, ret = 1'b0;
  logic [15:0] din = '0, dout;
  logic        full, empty, err;
  int          checks = 0, errors = 0;
  logic [15:0] m_pc = '0;
  logic [15:0] m_stk [$];
  logic        m_err = 1'b0;
  always #5 clk = ~clk;
  program_counter dut (
    .Clk(clk), .Reset(rst), .LD(ld), .Inc(inc), .Call(call), .Ret(ret),
    .DIn(din), .DOut(dout), .Full(full), .Empty(empty), .Err(err)
  );
  function automatic logic [18:0] model_out();
    return {m_pc, STK && m_stk.size() == 4, !STK || m_stk.size() == 0, m_err};
  endfunction
  task automatic step(input logic l, i, c, r, input logic [15:0] d);
    ld = l; inc = i; call = c; ret = r; din = d;
    @(posedge clk);
    m_err = 1'b0;
    if (r) begin
      if (STK) begin
        if (m_stk.size() == 0) m_err = 1'b1;
        else m_pc = m_stk.pop_back();
      end
    end else if (c) begin
      if (!STK) m_pc = d;
      else if (m_stk.size() == 4) m_err = 1'b1;
      else begin
        m_stk.push_back(m_pc + 16'd1);
        m_pc = d;
      end
    end else if (l) m_pc = d;
    else if (i) m_pc = m_pc + 16'd1;
    #1;
  endtask
  task automatic test_reset();
    #2;
    checks++;
    if ({dout, empty, err} !== {16'h0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold got %h/%b/%b want 0000/1/0", dout, empty, err);
    end
    @(negedge clk) rst = 1'b0;
    step(1, 0, 0, 0, 16'h1234);
    checks++;
    if (dout !== 16'h1234) begin
      errors++;
      $display("FAIL reset_preload got %h want 1234", dout);
    end
    step(0, 0, 0, 1, 16'h0000);
    checks++;
    if (err !== STK) begin
      errors++;
      $display("FAIL reset_err_setup got %b want %b", err, STK);
    end
    #2 rst = 1'b1;
    #1;
    m_pc = '0; m_stk.delete(); m_err = 1'b0;
    checks++;
    if ({dout, empty, err} !== {16'h0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_async got %h/%b/%b want 0000/1/0", dout, empty, err);
    end
    #2 rst = 1'b0;
    step(0, 1, 0, 0, 16'h0000);
    checks++;
    if (dout !== 16'h0001) begin
      errors++;
      $display("FAIL reset_first_op got %h want 0001", dout);
    end
  endtask
  task automatic test_load_inc();
    step(1, 0, 0, 0, 16'h00A0);
    checks++;
    if (dout !== 16'h00A0) begin
      errors++;
      $display("FAIL load got %h want 00a0", dout);
    end
    for (int k = 1; k <= 3; k++) begin
      step(0, 1, 0, 0, 16'hBEEF);
      checks++;
      if (dout !== 16'h00A0 + 16'(k)) begin
        errors++;
        $display("FAIL inc%0d got %h want %h", k, dout, 16'h00A0 + 16'(k));
      end
    end
    step(1, 0, 0, 0, 16'hFFFF);
    step(0, 1, 0, 0, 16'h0000);
    checks++;
    if (dout !== 16'h0000) begin
      errors++;
      $display("FAIL inc_wrap got %h want 0000", dout);
    end
  endtask
  task automatic test_call_ret();
    step(1, 0, 0, 0, 16'h0010);
    step(0, 0, 1, 0, 16'h0200);
    checks++;
    if (dout !== 16'h0200) begin
      errors++;
      $display("FAIL call got %h want 0200", dout);
    end
    step(0, 0, 0, 1, 16'h0000);
    checks++;
    if ({dout, empty, err} !== {(STK ? 16'h0011 : 16'h0200), 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ret got %h/%b/%b want %h/1/0", dout, empty, err, STK ? 16'h0011 : 16'h0200);
    end
  endtask
  task automatic test_overflow();
    step(1, 0, 0, 0, 16'h0000);
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 1, 0, 16'(k * 'h100));
      checks++;
      if ({dout, full} !== {16'(k * 'h100), STK && k == 4}) begin
        errors++;
        $display("FAIL call%0d got %h/%b want %h/%b", k, dout, full, 16'(k * 'h100), STK && k == 4);
      end
    end
    step(0, 0, 1, 0, 16'h0500);
    checks++;
    if ({dout, err} !== {(STK ? 16'h0400 : 16'h0500), STK}) begin
      errors++;
      $display("FAIL overflow got %h/%b want %h/%b", dout, err, STK ? 16'h0400 : 16'h0500, STK);
    end
    step(0, 0, 0, 0, 16'h0000);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL overflow_pulse got %b want 0", err);
    end
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 1, 16'h0000);
      checks++;
      if ({dout, full, empty, err} !== model_out()) begin
        errors++;
        $display("FAIL drain%0d got %h want %h", k, {dout, full, empty, err}, model_out());
      end
    end
  endtask
  task automatic test_underflow();
    step(1, 0, 0, 0, 16'h0050);
    step(0, 0, 0, 1, 16'h0000);
    checks++;
    if ({dout, empty, err} !== {16'h0050, 1'b1, STK}) begin
      errors++;
      $display("FAIL underflow got %h/%b/%b want 0050/1/%b", dout, empty, err, STK);
    end
    step(0, 0, 0, 0, 16'h0000);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL underflow_pulse got %b want 0", err);
    end
    step(1, 0, 0, 0, 16'h0010);
    step(0, 0, 1, 0, 16'h0900);
    step(1, 0, 1, 1, 16'h7777);
    checks++;
    if ({dout, empty, err} !== {(STK ? 16'h0011 : 16'h0900), 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL call_ret_ld got %h/%b/%b want %h/1/0", dout, empty, err, STK ? 16'h0011 : 16'h0900);
    end
  endtask
  task automatic test_no_stack();
    step(0, 0, 1, 0, 16'h0300);
    step(0, 0, 0, 1, 16'h0000);
    checks++;
    if ({dout, full, empty, err} !== model_out()) begin
      errors++;
      $display("FAIL call_then_ret got %h want %h", {dout, full, empty, err}, model_out());
    end
  endtask
  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0 ? 16'hFFFF : 16'($urandom));
      checks++;
      if ({dout, full, empty, err} !== model_out()) begin
        errors++;
        $display("FAIL random%0d got %h want %h", n, {dout, full, empty, err}, model_out());
      end
    end
  endtask
  initial begin
    test_reset();
    test_load_inc();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_no_stack();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
